// File: rtl/io_stream_loader.sv
// io_stream_loader: expands run-length-coded host words into a bitstream, packs
// it LSB-first into WORD_W-bit words and writes them to consecutive addresses
// starting at an image or filter base.
// Optional feature: define IOLOADER_CHECKSUM_EN to add a running XOR checksum
// output over all words written in the current stream.
module io_stream_loader #(
  parameter int unsigned       IN_W     = 16,
  parameter int unsigned       WORD_W   = 16,
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] IMG_BASE = '0,
  parameter logic [ADDR_W-1:0] FLT_BASE = ADDR_W'(16'h4000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [IN_W-1:0]   Din,
  output logic              ready,
  input  logic              cnn,
  input  logic              interrupt,
  output logic              done,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_data,
`ifdef IOLOADER_CHECKSUM_EN
  output logic [WORD_W-1:0] checksum,
`endif
  output logic              wrap
);

  localparam int unsigned RunW = IN_W - 1;
  localparam int unsigned CntW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {StIdle, StExpand, StFlush, StDone} state_e;

  state_e              state_q, state_d;
  logic [RunW-1:0]     run_q;
  logic                sym_q;
  logic [WORD_W-1:0]   pack_q;
  logic [CntW-1:0]     bitcnt_q;
  logic [ADDR_W-1:0]   base_q, idx_q;
  logic                started_q, irq_q, irq_d, wrap_q;
  logic                mem_wr_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [WORD_W-1:0]   mem_data_q;

  logic [RunW-1:0]     run_len;
  logic                accept, last_bit, full, flush_wr, wr_en;
  logic [WORD_W-1:0]   word_next, wr_data;
  logic [ADDR_W-1:0]   wr_addr;

  assign run_len   = Din[IN_W-2:0];
  assign accept    = load && ready;
  assign last_bit  = (state_q == StExpand) && (run_q == RunW'(1));
  assign word_next = pack_q | (WORD_W'(sym_q) << bitcnt_q);
  assign full      = (state_q == StExpand) && (bitcnt_q == CntW'(WORD_W - 1));
  assign flush_wr  = (state_q == StFlush) && (bitcnt_q != '0);
  assign wr_en     = full || flush_wr;
  assign wr_data   = full ? word_next : pack_q;
  assign wr_addr   = base_q + idx_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic; interrupt in DONE is ignored, a run always finishes first.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && run_len != '0) state_d = StExpand;
        else if (interrupt)          state_d = StFlush;
      end
      StExpand: begin
        if (last_bit) state_d = (irq_q || interrupt) ? StFlush : StIdle;
      end
      StFlush: state_d = StDone;
      StDone: begin
        if (accept) state_d = (run_len != '0) ? StExpand : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    ready = (state_q == StIdle) || (state_q == StDone);
    done  = (state_q == StDone);
  end

  // Pending-interrupt latch, consumed on entry to FLUSH.
  always_comb begin
    irq_d = irq_q;
    if (interrupt && ((state_q == StExpand) ||
                      (state_q == StIdle && accept && run_len != '0))) begin
      irq_d = 1'b1;
    end
    if (state_d == StFlush) irq_d = 1'b0;
  end

  // Expansion, packing and memory write datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= '0;
      sym_q      <= 1'b0;
      pack_q     <= '0;
      bitcnt_q   <= '0;
      base_q     <= '0;
      idx_q      <= '0;
      started_q  <= 1'b0;
      irq_q      <= 1'b0;
      wrap_q     <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      irq_q    <= irq_d;
      mem_wr_q <= 1'b0;
      if (accept) begin
        sym_q <= Din[IN_W-1];
        run_q <= run_len;
        // First word of a stream latches the region and restarts indexing.
        if (!started_q) begin
          started_q <= 1'b1;
          base_q    <= cnn ? FLT_BASE : IMG_BASE;
          idx_q     <= '0;
          wrap_q    <= 1'b0;
        end
      end
      if (state_q == StExpand) begin
        run_q <= run_q - RunW'(1);
        if (full) begin
          pack_q   <= '0;
          bitcnt_q <= '0;
        end else begin
          pack_q   <= word_next;
          bitcnt_q <= bitcnt_q + CntW'(1);
        end
      end
      if (state_q == StFlush) begin
        pack_q    <= '0;
        bitcnt_q  <= '0;
        started_q <= 1'b0;
      end
      if (wr_en) begin
        mem_wr_q   <= 1'b1;
        mem_addr_q <= wr_addr;
        mem_data_q <= wr_data;
        idx_q      <= idx_q + ADDR_W'(1);
        if (wr_addr == '1) wrap_q <= 1'b1;
      end
    end
  end

  assign mem_wr   = mem_wr_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign wrap     = wrap_q;

`ifdef IOLOADER_CHECKSUM_EN
  logic [WORD_W-1:0] chk_q;

  // Running XOR of written words, updated alongside the write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_q <= '0;
    end else if (accept && !started_q) begin
      chk_q <= '0;
    end else if (wr_en) begin
      chk_q <= chk_q ^ wr_data;
    end
  end

  assign checksum = chk_q;
`endif

endmodule

// File: tb/tb_io_stream_loader.sv
// Directed bench for io_stream_loader: table of streams with expected writes,
// plus a mid-run reset sequence.
module tb_io_stream_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] Din = '0;
  logic        ready;
  logic        cnn = 1'b0;
  logic        interrupt = 1'b0;
  logic        done;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        wrap;
`ifdef IOLOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  io_stream_loader dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .Din       (Din),
    .ready     (ready),
    .cnn       (cnn),
    .interrupt (interrupt),
    .done      (done),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
`ifdef IOLOADER_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            cnn;
    int              nw;
    logic [2:0][15:0] w;
    logic            mid_irq;
    int              nexp;
    logic [2:0][15:0] a;
    logic [2:0][15:0] d;
    logic            ready_hi;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] wq_addr[$];
  logic [15:0] wq_data[$];
  logic track = 1'b0;
  int rdy_low = 0;

  // Capture every write strobe and any ready drop while tracking.
  always @(negedge clk) begin
    if (mem_wr) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_data);
    end
    if (track && !ready) rdy_low++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic send(input logic [15:0] w);
    wait_ready();
    Din  = w;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [15:0] x;
    wq_addr.delete();
    wq_data.delete();
    rdy_low = 0;
    cnn = v.cnn;
    for (int k = 0; k < v.nw; k++) begin
      send(v.w[k]);
      if (k == 0) begin
        check($sformatf("v%0d_done_clr", id), 32'(done), 32'd0);
        track = 1'b1;
        cnn = ~v.cnn;  // mid-stream mode changes must have no effect
      end
    end
    if (v.mid_irq) repeat (10) @(negedge clk);
    else wait_ready();
    track = 1'b0;
    interrupt = 1'b1;
    @(negedge clk);
    interrupt = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    check($sformatf("v%0d_nwrites", id), 32'(wq_addr.size()), 32'(v.nexp));
    x = '0;
    for (int k = 0; k < v.nexp && k < wq_addr.size(); k++) begin
      check($sformatf("v%0d_addr%0d", id, k), 32'(wq_addr[k]), 32'(v.a[k]));
      check($sformatf("v%0d_data%0d", id, k), 32'(wq_data[k]), 32'(v.d[k]));
    end
    for (int k = 0; k < v.nexp; k++) x = x ^ v.d[k];
    check($sformatf("v%0d_done", id), 32'(done), 32'd1);
    check($sformatf("v%0d_ready", id), 32'(ready), 32'd1);
    check($sformatf("v%0d_wrap", id), 32'(wrap), 32'd0);
    if (v.ready_hi) check($sformatf("v%0d_ready_low_cycles", id), 32'(rdy_low), 32'd0);
`ifdef IOLOADER_CHECKSUM_EN
    check($sformatf("v%0d_checksum", id), 32'(checksum), 32'(x));
`endif
  endtask

  vec_t vecs[7];

  initial begin
    // Din = {symbol, 15-bit run length}
    vecs[0] = '{cnn: 1'b0, nw: 1, w: {16'h0, 16'h0, 16'h8010}, mid_irq: 1'b0, nexp: 1,
                a: {16'h0, 16'h0, 16'h0000}, d: {16'h0, 16'h0, 16'hFFFF}, ready_hi: 1'b0};
    vecs[1] = '{cnn: 1'b0, nw: 3, w: {16'h8008, 16'h0004, 16'h8004}, mid_irq: 1'b0, nexp: 1,
                a: {16'h0, 16'h0, 16'h0000}, d: {16'h0, 16'h0, 16'hFF0F}, ready_hi: 1'b0};
    vecs[2] = '{cnn: 1'b1, nw: 1, w: {16'h0, 16'h0, 16'h8003}, mid_irq: 1'b0, nexp: 1,
                a: {16'h0, 16'h0, 16'h4000}, d: {16'h0, 16'h0, 16'h0007}, ready_hi: 1'b0};
    vecs[3] = '{cnn: 1'b0, nw: 1, w: {16'h0, 16'h0, 16'h0000}, mid_irq: 1'b0, nexp: 0,
                a: {16'h0, 16'h0, 16'h0}, d: {16'h0, 16'h0, 16'h0}, ready_hi: 1'b1};
    vecs[4] = '{cnn: 1'b0, nw: 1, w: {16'h0, 16'h0, 16'h8028}, mid_irq: 1'b1, nexp: 3,
                a: {16'h0002, 16'h0001, 16'h0000}, d: {16'h00FF, 16'hFFFF, 16'hFFFF},
                ready_hi: 1'b0};
    vecs[5] = '{cnn: 1'b1, nw: 2, w: {16'h0, 16'h800C, 16'h0014}, mid_irq: 1'b0, nexp: 2,
                a: {16'h0, 16'h4001, 16'h4000}, d: {16'h0, 16'hFFF0, 16'h0000},
                ready_hi: 1'b0};
    // Fresh stream after a mid-run reset; stale partial bits would corrupt the word.
    vecs[6] = '{cnn: 1'b0, nw: 1, w: {16'h0, 16'h0, 16'h8008}, mid_irq: 1'b0, nexp: 1,
                a: {16'h0, 16'h0, 16'h0000}, d: {16'h0, 16'h0, 16'h00FF}, ready_hi: 1'b0};

    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", 32'(mem_data), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset five cycles into a {1,20} run.
    wq_addr.delete();
    wq_data.delete();
    cnn = 1'b0;
    send(16'h8014);
    repeat (4) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("mrst_ready", 32'(ready), 32'd1);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_mem_wr", 32'(mem_wr), 32'd0);
    check("mrst_mem_addr", 32'(mem_addr), 32'd0);
    check("mrst_mem_data", 32'(mem_data), 32'd0);
    check("mrst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    check("mrst_no_write", 32'(wq_addr.size()), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    run_vec(vecs[6], 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
